// File: rtl/video_scale_pkg.sv
// Shared constants, state encoding and trim/divisor helpers
// for the zoom-controlled video down-scaler.
package video_scale_pkg;

    localparam int VIN_XRES    = 1920;
    localparam int VIN_YRES    = 1080;
    localparam int VOUT_XRES   = 960;
    localparam int VOUT_YRES   = 540;
    localparam int STEP_X      = 32;
    localparam int STEP_Y      = 18;
    localparam int LEVEL_MAX   = 20;
    localparam int AUTO_FRAMES = 60;
    localparam int FRAC_W      = 16;
    localparam int LVL_W       = 5;

    localparam logic [31:0] SCALE_RST = 32'h0002_0001;
    localparam logic [31:0] DVD_X     = 32'(VIN_XRES << FRAC_W);
    localparam logic [31:0] DVD_Y     = 32'(VIN_YRES << FRAC_W);

    typedef enum logic [2:0] {
        IDLE,
        DIV_W,
        DIV_H,
        WAIT_VS,
        COMMIT
    } state_t;

    function automatic logic [9:0] trim_x(input logic [LVL_W-1:0] lvl);
        return 10'(int'(lvl) * STEP_X);
    endfunction

    function automatic logic [9:0] trim_y(input logic [LVL_W-1:0] lvl);
        return 10'(int'(lvl) * STEP_Y);
    endfunction

    function automatic logic [9:0] dsr_x(input logic [LVL_W-1:0] lvl);
        return 10'(VOUT_XRES - int'(lvl) * STEP_X);
    endfunction

    function automatic logic [9:0] dsr_y(input logic [LVL_W-1:0] lvl);
        return 10'(VOUT_YRES - int'(lvl) * STEP_Y);
    endfunction

endpackage

// File: rtl/scale_div_seq.sv
// Restoring divider: 32-bit dividend / 10-bit divisor,
// one quotient bit per cycle, done pulses after 32 steps.
module scale_div_seq
    import video_scale_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [31:0] i_dividend,
    input  logic [9:0]  i_divisor,
    output logic        o_done,
    output logic [31:0] o_quot
);

    logic [31:0] r_dvd;
    logic [10:0] r_rem;
    logic [9:0]  r_div;
    logic [5:0]  r_cnt;
    logic        r_done;

    logic [11:0] w_trial;
    logic [10:0] w_diff;
    logic        w_ge;
    logic [10:0] w_rem_nx;

    assign w_trial  = {r_rem, r_dvd[31]};
    assign w_diff   = w_trial[10:0] - {1'b0, r_div};
    assign w_ge     = w_trial >= {2'b00, r_div};
    assign w_rem_nx = w_ge ? w_diff : w_trial[10:0];

    // Shift one dividend bit into the remainder per cycle;
    // quotient bits fill r_dvd from the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvd  <= '0;
            r_rem  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_dvd  <= i_dividend;
            r_rem  <= '0;
            r_div  <= i_divisor;
            r_cnt  <= 6'd32;
            r_done <= 1'b0;
        end else if (r_cnt != '0) begin
            r_rem  <= w_rem_nx;
            r_dvd  <= {r_dvd[30:0], w_ge};
            r_cnt  <= r_cnt - 6'd1;
            r_done <= (r_cnt == 6'd1);
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_done = r_done;
    assign o_quot = r_dvd;

endmodule

// File: rtl/video_scale_ctrl.sv
// Zoom controller: key pulses -> level, trims and 16.16 factors,
// committed atomically on vsync. Option: VIDEO_SCALE_AUTO_ZOOM_EN.
module video_scale_ctrl
    import video_scale_pkg::*;
(
    input  logic        pixclk_in,
    input  logic        rst_n,
    input  logic        vs_in,
    input  logic        zoom_in_req,
    input  logic        zoom_out_req,
    output logic [9:0]  cnt_x,
    output logic [9:0]  cnt_y,
    output logic [31:0] scaler_width,
    output logic [31:0] scaler_height,
    output logic        cfg_update,
    output logic        busy
);

    state_t             r_state;
    state_t             w_state_nx;
    logic               r_vs_d;
    logic [LVL_W-1:0]   r_level;
    logic [LVL_W-1:0]   r_next_level;
    logic [31:0]        r_shadow_w;
    logic [31:0]        r_shadow_h;
    logic [9:0]         r_cnt_x;
    logic [9:0]         r_cnt_y;
    logic [31:0]        r_scale_w;
    logic [31:0]        r_scale_h;
    logic               r_pend_v;
    logic               r_pend_up;

    logic               w_vs_rise;
    logic               w_ext;
    logic               w_auto_up;
    logic               w_auto_dn;
    logic               w_req_up;
    logic               w_req_dn;
    logic               w_req_any;
    logic               w_cand_v;
    logic               w_cand_up;
    logic               w_ok;
    logic [LVL_W-1:0]   w_tgt;
    logic               w_launch;
    logic               w_div_start;
    logic [31:0]        w_div_dvd;
    logic [9:0]         w_div_dsr;
    logic               w_div_done;
    logic [31:0]        w_div_q;

    assign w_vs_rise = vs_in & ~r_vs_d;
    assign w_ext     = zoom_in_req | zoom_out_req;

`ifdef VIDEO_SCALE_AUTO_ZOOM_EN
    logic [5:0] r_frm_cnt;
    logic       r_auto_up;
    logic       w_auto_fire;
    logic       w_auto_dir;

    assign w_auto_fire = w_vs_rise & ~w_ext &
                         (r_frm_cnt == 6'(AUTO_FRAMES - 1));
    assign w_auto_dir  = r_auto_up ?
                         (r_level != LVL_W'(LEVEL_MAX)) :
                         (r_level == '0);
    assign w_auto_up   = w_auto_fire & w_auto_dir;
    assign w_auto_dn   = w_auto_fire & ~w_auto_dir;

    // Frame counter and ping-pong direction for automatic zoom
    always_ff @(posedge pixclk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_frm_cnt <= '0;
            r_auto_up <= 1'b1;
        end else if (w_ext) begin
            r_frm_cnt <= '0;
        end else if (w_vs_rise) begin
            if (w_auto_fire) begin
                r_frm_cnt <= '0;
                r_auto_up <= w_auto_dir;
            end else begin
                r_frm_cnt <= r_frm_cnt + 6'd1;
            end
        end
    end
`else
    assign w_auto_up = 1'b0;
    assign w_auto_dn = 1'b0;
`endif

    assign w_req_up  = (zoom_in_req & ~zoom_out_req) | w_auto_up;
    assign w_req_dn  = (zoom_out_req & ~zoom_in_req) | w_auto_dn;
    assign w_req_any = w_req_up | w_req_dn;

    // A fresh request takes priority over the pending slot
    assign w_cand_v  = w_req_any | ((r_state == COMMIT) & r_pend_v);
    assign w_cand_up = w_req_any ? w_req_up : r_pend_up;
    assign w_ok      = w_cand_v & (w_cand_up ?
                       (r_level < LVL_W'(LEVEL_MAX)) :
                       (r_level != '0));
    assign w_tgt     = w_cand_up ? r_level + 1'b1 : r_level - 1'b1;

    // Next-state and divider launch decode
    always_comb begin
        w_state_nx  = r_state;
        w_launch    = 1'b0;
        w_div_start = 1'b0;
        w_div_dvd   = DVD_X;
        w_div_dsr   = dsr_x(w_tgt);
        unique case (r_state)
            IDLE, COMMIT: begin
                w_state_nx = IDLE;
                if (w_ok) begin
                    w_launch    = 1'b1;
                    w_div_start = 1'b1;
                    w_state_nx  = DIV_W;
                end
            end
            DIV_W: begin
                w_div_dvd = DVD_Y;
                w_div_dsr = dsr_y(r_next_level);
                if (w_div_done) begin
                    w_div_start = 1'b1;
                    w_state_nx  = DIV_H;
                end
            end
            DIV_H: begin
                if (w_div_done) w_state_nx = WAIT_VS;
            end
            WAIT_VS: begin
                if (w_vs_rise) w_state_nx = COMMIT;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // State, shadow, pending and committed output registers
    always_ff @(posedge pixclk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_vs_d       <= 1'b0;
            r_level      <= '0;
            r_next_level <= '0;
            r_shadow_w   <= SCALE_RST;
            r_shadow_h   <= SCALE_RST;
            r_cnt_x      <= '0;
            r_cnt_y      <= '0;
            r_scale_w    <= SCALE_RST;
            r_scale_h    <= SCALE_RST;
            r_pend_v     <= 1'b0;
            r_pend_up    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_vs_d  <= vs_in;
            if (w_launch) r_next_level <= w_tgt;
            if (r_state == DIV_W && w_div_done)
                r_shadow_w <= w_div_q + 32'd1;
            if (r_state == DIV_H && w_div_done)
                r_shadow_h <= w_div_q + 32'd1;
            if (r_state == WAIT_VS && w_vs_rise) begin
                r_level   <= r_next_level;
                r_cnt_x   <= trim_x(r_next_level);
                r_cnt_y   <= trim_y(r_next_level);
                r_scale_w <= r_shadow_w;
                r_scale_h <= r_shadow_h;
            end
            if (r_state == COMMIT) begin
                r_pend_v <= 1'b0;
            end else if (r_state != IDLE && w_req_any) begin
                r_pend_v  <= 1'b1;
                r_pend_up <= w_req_up;
            end
        end
    end

    scale_div_seq u_div (
        .clk        (pixclk_in),
        .rst_n      (rst_n),
        .i_start    (w_div_start),
        .i_dividend (w_div_dvd),
        .i_divisor  (w_div_dsr),
        .o_done     (w_div_done),
        .o_quot     (w_div_q)
    );

    assign cnt_x         = r_cnt_x;
    assign cnt_y         = r_cnt_y;
    assign scaler_width  = r_scale_w;
    assign scaler_height = r_scale_h;
    assign cfg_update    = (r_state == COMMIT);
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_video_scale_ctrl.sv
// Directed bench for video_scale_ctrl: reset, single zoom, pending,
// early vsync, ignored requests, saturation and mid-divide reset.
module tb_video_scale_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs_in = 1'b0;
    logic        zin = 1'b0;
    logic        zout = 1'b0;
    logic [9:0]  cnt_x;
    logic [9:0]  cnt_y;
    logic [31:0] sw;
    logic [31:0] sh;
    logic        cfg_update;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;
    int cfg_cnt = 0;

    video_scale_ctrl dut (
        .pixclk_in     (clk),
        .rst_n         (rst_n),
        .vs_in         (vs_in),
        .zoom_in_req   (zin),
        .zoom_out_req  (zout),
        .cnt_x         (cnt_x),
        .cnt_y         (cnt_y),
        .scaler_width  (sw),
        .scaler_height (sh),
        .cfg_update    (cfg_update),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && cfg_update) cfg_cnt++;

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic up, input logic dn);
        @(posedge clk); #1;
        zin = up; zout = dn;
        @(posedge clk); #1;
        zin = 1'b0; zout = 1'b0;
    endtask

    task automatic vs_pulse();
        @(posedge clk); #1;
        vs_in = 1'b1;
        wait_cyc(2);
        vs_in = 1'b0;
        wait_cyc(3);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2);
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (cnt_x !== 10'd0 || cnt_y !== 10'd0)
            $display("FAIL reset_cnt got %0d/%0d exp 0/0", cnt_x, cnt_y);
        else n_pass++;
        n_total++;
        if (sw !== 32'h00020001 || sh !== 32'h00020001)
            $display("FAIL reset_scale got %h/%h exp 00020001", sw, sh);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0 || cfg_update !== 1'b0)
            $display("FAIL reset_flags got busy=%b cfg=%b exp 0/0",
                     busy, cfg_update);
        else n_pass++;
    endtask

    task automatic test_single_zoom();
        int c0;
        c0 = cfg_cnt;
        pulse(1'b1, 1'b0);
        wait_cyc(100);
        n_total++;
        if (busy !== 1'b1 || cnt_x !== 10'd0)
            $display("FAIL single_wait got busy=%b cnt_x=%0d exp 1/0",
                     busy, cnt_x);
        else n_pass++;
        vs_pulse();
        n_total++;
        if (cnt_x !== 10'd32 || cnt_y !== 10'd18)
            $display("FAIL single_cnt got %0d/%0d exp 32/18", cnt_x, cnt_y);
        else n_pass++;
        n_total++;
        if (sw !== 32'h000211A8 || sh !== 32'h000211A8)
            $display("FAIL single_scale got %h/%h exp 000211a8", sw, sh);
        else n_pass++;
        n_total++;
        if (cfg_cnt - c0 !== 1 || busy !== 1'b0)
            $display("FAIL single_cfg got pulses=%0d busy=%b exp 1/0",
                     cfg_cnt - c0, busy);
        else n_pass++;
    endtask

    task automatic test_early_vs();
        int c0;
        c0 = cfg_cnt;
        pulse(1'b1, 1'b0);
        wait_cyc(10);
        vs_pulse();
        n_total++;
        if (cfg_cnt !== c0 || cnt_x !== 10'd32 || sw !== 32'h000211A8)
            $display("FAIL early_vs_hold got cfg=%0d cnt_x=%0d sw=%h exp 0/32/000211a8",
                     cfg_cnt - c0, cnt_x, sw);
        else n_pass++;
        wait_cyc(100);
        vs_pulse();
        n_total++;
        if (cnt_x !== 10'd64 || cnt_y !== 10'd36)
            $display("FAIL early_vs_cnt got %0d/%0d exp 64/36", cnt_x, cnt_y);
        else n_pass++;
        n_total++;
        if (sw !== 32'h00022493 || sh !== 32'h00022493)
            $display("FAIL early_vs_scale got %h/%h exp 00022493", sw, sh);
        else n_pass++;
    endtask

    task automatic test_pending();
        pulse(1'b0, 1'b1);
        wait_cyc(5);
        pulse(1'b0, 1'b1);
        wait_cyc(100);
        vs_pulse();
        n_total++;
        if (cnt_x !== 10'd32 || busy !== 1'b1)
            $display("FAIL pending_first got cnt_x=%0d busy=%b exp 32/1",
                     cnt_x, busy);
        else n_pass++;
        wait_cyc(100);
        vs_pulse();
        n_total++;
        if (cnt_x !== 10'd0 || sw !== 32'h00020001 || busy !== 1'b0)
            $display("FAIL pending_second got cnt_x=%0d sw=%h busy=%b exp 0/00020001/0",
                     cnt_x, sw, busy);
        else n_pass++;
    endtask

    task automatic test_ignored();
        int c0;
        c0 = cfg_cnt;
        pulse(1'b0, 1'b1);
        wait_cyc(2);
        n_total++;
        if (busy !== 1'b0)
            $display("FAIL ignore_out_busy got %b exp 0", busy);
        else n_pass++;
        pulse(1'b1, 1'b1);
        wait_cyc(2);
        n_total++;
        if (busy !== 1'b0)
            $display("FAIL ignore_both_busy got %b exp 0", busy);
        else n_pass++;
        wait_cyc(80);
        vs_pulse();
        n_total++;
        if (cfg_cnt !== c0 || cnt_x !== 10'd0 || sh !== 32'h00020001)
            $display("FAIL ignore_outputs got cfg=%0d cnt_x=%0d sh=%h exp 0/0/00020001",
                     cfg_cnt - c0, cnt_x, sh);
        else n_pass++;
    endtask

    task automatic test_saturate();
        int c0;
        int lv;
        for (int i = 1; i <= 25; i++) begin
            c0 = cfg_cnt;
            lv = (i > 20) ? 20 : i;
            pulse(1'b1, 1'b0);
            wait_cyc(80);
            vs_pulse();
            n_total++;
            if (cnt_x !== 10'(lv * 32) || cfg_cnt - c0 !== (i > 20 ? 0 : 1))
                $display("FAIL sat_step%0d got cnt_x=%0d cfg=%0d exp %0d/%0d",
                         i, cnt_x, cfg_cnt - c0, lv * 32, (i > 20 ? 0 : 1));
            else n_pass++;
        end
        n_total++;
        if (cnt_y !== 10'd360 || busy !== 1'b0)
            $display("FAIL sat_cnt_y got %0d busy=%b exp 360/0", cnt_y, busy);
        else n_pass++;
        n_total++;
        if (sw !== 32'h00060001 || sh !== 32'h00060001)
            $display("FAIL sat_scale got %h/%h exp 00060001", sw, sh);
        else n_pass++;
    endtask

    task automatic test_reset_mid_div();
        int c0;
        pulse(1'b1, 1'b0);
        wait_cyc(80);
        vs_pulse();
        pulse(1'b1, 1'b0);
        wait_cyc(45);
        n_total++;
        if (busy !== 1'b1 || cnt_x !== 10'd32)
            $display("FAIL middiv_pre got busy=%b cnt_x=%0d exp 1/32",
                     busy, cnt_x);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (cnt_x !== 10'd0 || cnt_y !== 10'd0 || busy !== 1'b0)
            $display("FAIL middiv_async got cnt=%0d/%0d busy=%b exp 0/0/0",
                     cnt_x, cnt_y, busy);
        else n_pass++;
        n_total++;
        if (sw !== 32'h00020001 || sh !== 32'h00020001)
            $display("FAIL middiv_scale got %h/%h exp 00020001", sw, sh);
        else n_pass++;
        wait_cyc(2);
        rst_n = 1'b1;
        c0 = cfg_cnt;
        wait_cyc(60);
        vs_pulse();
        n_total++;
        if (cfg_cnt !== c0 || cnt_x !== 10'd0 || busy !== 1'b0)
            $display("FAIL middiv_after got cfg=%0d cnt_x=%0d busy=%b exp 0/0/0",
                     cfg_cnt - c0, cnt_x, busy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_zoom();
        test_early_vs();
        test_pending();
        do_reset();
        test_ignored();
        test_saturate();
        do_reset();
        test_reset_mid_div();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/video_scale_ctrl.md
Name: video_scale_ctrl

Overview:
Zoom controller for the 1920x1080 nearest-neighbour down-scaler. Converts zoom-in/zoom-out key pulses into a zoom level and derives the scaler's cnt_x/cnt_y trim values. Computes the 16.16 scale factors with a sequential divider instead of combinational division. Commits all four values together on a vs_in rising edge, so a frame never uses a mixed configuration.

Parameters:
VIN_XRES, 1920, input frame width
VIN_YRES, 1080, input frame height
VOUT_XRES, 960, output width at level 0
VOUT_YRES, 540, output height at level 0
STEP_X, 32, cnt_x increment per level
STEP_Y, 18, cnt_y increment per level (16:9 preserved)
LEVEL_MAX, 20, highest zoom level (gives 320x180 output)
AUTO_FRAMES, 60, frames per automatic step (optional feature only)

Ports:
pixclk_in  in  1  pixel clock; only clock
rst_n  in  1  reset, asynchronous, active-low
vs_in  in  1  input vsync, active-high
zoom_in_req  in  1  one-cycle pulse: level+1
zoom_out_req  in  1  one-cycle pulse: level-1
cnt_x  out  10  committed width trim = level*STEP_X
cnt_y  out  10  committed height trim = level*STEP_Y
scaler_width  out  32  committed ((VIN_XRES<<16)/(VOUT_XRES-cnt_x))+1
scaler_height  out  32  committed ((VIN_YRES<<16)/(VOUT_YRES-cnt_y))+1
cfg_update  out  1  one-cycle pulse on the commit cycle
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: level=0, cnt_x=0, cnt_y=0, scaler_width=scaler_height=0x00020001, cfg_update=0, busy=0, FSM=IDLE, vs_d=0, pending=none.
- vs edge detection: vs_d registers vs_in. Rising edge is vs_in & ~vs_d.
- Request decode (all states):
  - zoom_in_req and zoom_out_req high together: both ignored.
  - A request that would move level below 0 or above LEVEL_MAX: ignored.
- IDLE: a valid request sets next_level = level±1 and moves to DIV_W. The request is consumed.
- DIV_W: divides VIN_XRES<<16 by VOUT_XRES-next_level*STEP_X.
  - Restoring divider, one quotient bit per cycle, 32 cycles.
  - Result+1 goes to shadow_w, then move to DIV_H.
- DIV_H: same operation for height into shadow_h, 32 cycles, then WAIT_VS.
- WAIT_VS: on a vs rising edge go to COMMIT.
- COMMIT (1 cycle):
  - cnt_x, cnt_y, scaler_width, scaler_height and level load from the shadow registers simultaneously.
  - cfg_update=1.
  - Go to IDLE, or to DIV_W if a pending request exists.
- Requests arriving while busy go into a one-deep pending slot; the newest request overwrites it.
  - At COMMIT, the pending request is re-validated against the new level (saturation) before it is accepted.
- Latency: request to shadow ready = 65 cycles. Commit happens on the cycle after the first vs rising edge following that.
- A vs edge during DIV_W or DIV_H does not commit; the block waits for the next frame.
- Width rules: dividend is 32 bits, divisor 10 bits, remainder 11 bits. Divisor is never 0, because LEVEL_MAX*STEP_X < VOUT_XRES.
- Reset mid-division: the divider is abandoned and all outputs return to reset values immediately.

Optional Feature:
VIDEO_SCALE_AUTO_ZOOM_EN
- Defined: an internal frame counter counts vs rising edges.
  - Every AUTO_FRAMES frames it issues an internal request.
  - Direction ping-pongs: up to LEVEL_MAX, then down to 0.
  - External requests are still honoured and reset the frame counter.
- Undefined: the counter and direction logic are absent; only external requests change the level.

Decomposition:
- video_scale_pkg holds:
  - resolution defaults and STEP_X/STEP_Y
  - the 16.16 fraction width (16)
  - the state enum {IDLE, DIV_W, DIV_H, WAIT_VS, COMMIT}
  - the reset scale constant 0x00020001
- One sub-module, scale_div_seq: start/done handshake, 32-bit dividend, 10-bit divisor, 32-cycle restoring divider. It is instantiated once and reused for width and height.

Test Plan:
- Release reset with no requests -> cnt_x=0, cnt_y=0, scaler_width=scaler_height=0x00020001, busy=0.
- One zoom_in_req pulse, then vs pulse after 100 cycles -> cnt_x=32, cnt_y=18, scaler_width=scaler_height=0x000211A8; cfg_update for 1 cycle; busy low afterwards.
- 25 zoom_in_req pulses, each followed by a frame -> level saturates at 20; cnt_x=640, cnt_y=360, factors=0x00060001. Requests 21-25 produce no cfg_update.
- zoom_out_req at level 0 -> no busy, outputs unchanged. Simultaneous zoom_in_req+zoom_out_req -> ignored.
- vs pulse 10 cycles after a request -> no commit on that edge; commit on the next vs edge. Outputs are stable until then.
- rst_n low during DIV_H -> outputs are reset values within the same cycle, FSM=IDLE, and no commit on the following vs.
